// File: rtl/delta_event_fifo.sv
// Timestamped event FIFO behind the XOR delta engine: first-word-fall-through output, sticky overflow and saturating drop counter.
// Optional macro DELTA_EVENT_FIFO_POPCNT_EN stores a 7-bit popcount of each delta alongside it.
module delta_event_fifo #(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            delta_word,
  input  logic                   event_valid,
  input  logic                   output_ready,
  input  logic                   out_ready,
  input  logic                   clr_overflow,
  output logic                   out_valid,
  output logic [63:0]            out_delta,
  output logic [TS_WIDTH-1:0]    out_ts,
  output logic [6:0]             out_popcount,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_FULL} state_t;

  state_t              state, state_nxt;
  logic [63:0]         mem_delta [DEPTH];
  logic [TS_WIDTH-1:0] mem_ts    [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [CW-1:0]       count_nxt;
  logic                push_req, pop, full, push_acc, drop, bypass;

  assign push_req   = output_ready && event_valid;
  assign pop        = out_valid && out_ready;
  assign full       = (fifo_count == CW'(DEPTH));
  assign push_acc   = push_req && (!full || pop);
  assign drop       = push_req && !push_acc;
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  // The incoming word becomes the head when nothing older remains after this cycle's pop.
  assign bypass     = push_acc && ((fifo_count == '0) || (fifo_count == CW'(1) && pop));
  assign out_valid  = (state != ST_EMPTY);

  always_comb begin
    count_nxt = fifo_count;
    if (push_acc && !pop)      count_nxt = fifo_count + CW'(1);
    else if (pop && !push_acc) count_nxt = fifo_count - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY:  if (push_acc) state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (count_nxt == CW'(DEPTH)) state_nxt = ST_FULL;
        else if (count_nxt == '0)    state_nxt = ST_EMPTY;
      end
      ST_FULL:   if (pop && !push_acc) state_nxt = ST_ACTIVE;
      default:   state_nxt = ST_EMPTY;
    endcase
  end

`ifdef DELTA_EVENT_FIFO_POPCNT_EN
  logic [6:0] mem_pc [DEPTH];
  logic [6:0] in_pc;

  always_comb begin
    in_pc = 7'd0;
    for (int i = 0; i < 64; i++) in_pc = in_pc + 7'(delta_word[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem_pc[wr_ptr] <= in_pc;
  end

  always_ff @(posedge clk) begin
    if (rst)                                    out_popcount <= 7'd0;
    else if (bypass)                            out_popcount <= in_pc;
    else if (pop && count_nxt != '0)            out_popcount <= mem_pc[rd_ptr_nxt];
  end
`else
  assign out_popcount = 7'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem_delta[wr_ptr] <= delta_word;
      mem_ts[wr_ptr]    <= ts_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ts_cnt     <= '0;
      fifo_count <= '0;
      out_delta  <= '0;
      out_ts     <= '0;
      overflow   <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      state      <= state_nxt;
      ts_cnt     <= ts_cnt + TS_WIDTH'(1);
      fifo_count <= count_nxt;
      rd_ptr     <= rd_ptr_nxt;
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (bypass) begin
        out_delta <= delta_word;
        out_ts    <= ts_cnt;
      end else if (pop && count_nxt != '0) begin
        out_delta <= mem_delta[rd_ptr_nxt];
        out_ts    <= mem_ts[rd_ptr_nxt];
      end
      // A drop in the same cycle as a clear restarts the tally at one.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_overflow)                 drop_count <= 16'd1;
        else if (drop_count != 16'hFFFF)  drop_count <= drop_count + 16'd1;
      end else if (clr_overflow) begin
        overflow   <= 1'b0;
        drop_count <= 16'd0;
      end
    end
  end

endmodule

// File: doc/delta_event_fifo.md
Name: delta_event_fifo

Overview:
- Sits directly downstream of the 64-bit XOR delta engine.
- Captures each delta word flagged as a significant change event, stamps it with a free-running cycle timestamp, and buffers it in a synchronous FIFO.
- Presents events on a valid/ready stream for the host/UART packetiser on the Tang Nano 9K.
- Absorbs bursts and counts events dropped on overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..64.
- TS_WIDTH, 16, timestamp counter width in bits.

Ports:
- clk  in  1  27 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- delta_word  in  64  delta from upstream engine.
- event_valid  in  1  upstream flags delta as a significant event.
- output_ready  in  1  upstream output strobe, one cycle per delta.
- out_ready  in  1  downstream consumer accepts the head entry.
- clr_overflow  in  1  clears the overflow flag and drop_count.
- out_valid  out  1  FIFO non-empty; head entry presented.
- out_delta  out  64  head entry delta word.
- out_ts  out  TS_WIDTH  head entry timestamp.
- out_popcount  out  7  head entry set-bit count (see Optional Feature).
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky: at least one event dropped.
- drop_count  out  16  saturating count of dropped events.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst). All state is updated on posedge clk only.
- Reset values:
  - out_valid=0, out_delta=0, out_ts=0, out_popcount=0.
  - fifo_count=0, overflow=0, drop_count=0.
  - Read/write pointers and timestamp counter = 0.
- Timestamp counter:
  - Increments by 1 every cycle after reset.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Push request: push_req = output_ready && event_valid.
  - Deltas with output_ready=1 and event_valid=0 are discarded silently and are not counted.
  - The entry stores the delta_word and timestamp counter values sampled in the same cycle as push_req.
- Pop: pop = out_valid && out_ready. With out_ready=1 while empty, nothing happens.
- Push acceptance: push is accepted when fifo_count<DEPTH, or when fifo_count==DEPTH and pop is asserted in the same cycle.
  - The simultaneous push+pop at full is accepted; fifo_count stays DEPTH.
- Simultaneous push and pop at empty:
  - The entry is written; fifo_count becomes 1.
  - The pop is ignored because out_valid=0 that cycle.
- Output is first-word-fall-through:
  - out_valid and out_* are registered and reflect the head entry.
  - Latency from accepted push into an empty FIFO to out_valid=1 is 1 cycle.
  - While out_valid=1 and out_ready=0, out_* hold stable.
- Rejected push (full, no pop):
  - Entry discarded; overflow set to 1.
  - drop_count incremented, saturating at 16'hFFFF.
- clr_overflow:
  - Next cycle: overflow=0 and drop_count=0.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from fifo_count, not from pointer equality.
- fifo_count changes: +1 on push-only, -1 on pop-only, unchanged on push+pop or idle.
- Control state machine: EMPTY, ACTIVE, FULL.
  - EMPTY -> ACTIVE on an accepted push.
  - ACTIVE -> FULL when fifo_count reaches DEPTH.
  - ACTIVE -> EMPTY when fifo_count reaches 0.
  - FULL -> ACTIVE on a pop without a push.
  - The state must always be consistent with fifo_count.
- rst asserted mid-operation:
  - All contents are lost; outputs return to reset values on the next edge.
  - No pop handshake is reported for the flushed entries.

Optional Feature:
- Macro: DELTA_EVENT_FIFO_POPCNT_EN.
- Defined: each entry also stores the 7-bit population count (0..64) of delta_word, computed combinationally at push. out_popcount presents the head entry's value.
- Undefined: no popcount logic or storage is built; out_popcount is tied to 7'd0.
- All other behaviour is identical with or without the macro.

Test Plan:
- Single event: after reset, pulse output_ready=1, event_valid=1, delta_word=64'h0000_0000_0000_00FF in cycle 10 (ts=10) -> next cycle out_valid=1, out_delta=64'hFF, out_ts=10, fifo_count=1. out_popcount=8 with the macro defined, 0 without.
- Filter: output_ready=1, event_valid=0, delta=64'h1 -> out_valid stays 0, fifo_count=0, drop_count=0.
- Fill and overflow: out_ready=0, push 18 events into DEPTH=16 -> fifo_count=16, overflow=1, drop_count=2. Then drain with out_ready=1 -> the 16 retained entries emerge in push order, out_valid deasserts after the 16th.
- Full with simultaneous push+pop: at fifo_count=16, assert push and out_ready together -> push accepted, fifo_count=16, overflow unchanged, the new entry emerges last.
- Backpressure stability: out_valid=1, out_ready=0 for 5 cycles while pushing 2 events -> out_delta/out_ts unchanged, fifo_count increases by 2.
- Reset and clear: clr_overflow=1 with overflow=1 and drop_count=3 -> both 0 next cycle. rst=1 with fifo_count=7 -> next cycle fifo_count=0, out_valid=0, and the timestamp restarts at 0.
